// File: rtl/nibble_packer_if.sv
// Nibble-in / word-out handshake bundle for nibble_packer.
// slave is the packer's view; master is the upstream/downstream driver's view.
interface nibble_packer_if #(
    parameter int DW = 4,
    parameter int N  = 4
);
    localparam int CW = $clog2(N);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N*DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] nib_cnt;
    logic          overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output nib_cnt, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  nib_cnt, overflow
    );
endinterface

// File: rtl/nibble_packer.sv
// Packs N consecutive nibbles into one word; double-buffered
// so the accumulator keeps filling while a finished word waits.
module nibble_packer #(
    parameter int DW        = 4,
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    nibble_packer_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int AW = (N - 1) * DW;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    logic [N*DW-1:0] word;
    logic [N*DW-1:0] out_data;
    logic [CW-1:0]   nib_cnt;
    logic            out_valid;
    logic            overflow;
    logic            out_free;
    logic            last;
    logic            in_ready;
    logic            accept;

    assign out_free = !out_valid || bus.out_ready;
    assign last     = (nib_cnt == LAST);
    assign in_ready = !last || out_free;
    assign accept   = bus.in_valid && in_ready;

    // Accumulator only holds N-1 nibbles; the last one joins on the fly.
    always_comb begin
        word    = '0;
        acc_nxt = acc;
        if (MSB_FIRST) begin
            word    = {acc, bus.in_data};
            acc_nxt = word[AW-1:0];
        end else begin
            word = {bus.in_data, acc};
            acc_nxt[int'(nib_cnt)*DW +: DW] = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            nib_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (out_valid && bus.out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (last) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                    nib_cnt   <= '0;
                end else begin
                    acc     <= acc_nxt;
                    nib_cnt <= nib_cnt + CW'(1);
                end
            end
            if (bus.in_valid && !in_ready)
                overflow <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.nib_cnt   = nib_cnt;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_nibble_packer.sv
// Drives an MSB-first and an LSB-first packer with shared stimulus
// and checks both against a queue-based model every cycle.
module tb_nibble_packer;
    localparam int DW = 4;
    localparam int N  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       out_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nibble_packer_if #(.DW(DW), .N(N)) ia ();
    nibble_packer_if #(.DW(DW), .N(N)) ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_data   = in_data;
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_data   = in_data;
    assign ib.out_ready = out_ready;

    nibble_packer #(.DW(DW), .N(N), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    nibble_packer #(.DW(DW), .N(N), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: pending nibbles in arrival order plus one held word.
    logic [3:0]  nibq[$];
    bit          m_valid = 0;
    bit          m_ovf = 0;
    bit          armed = 0;
    logic [15:0] m_wa = '0;
    logic [15:0] m_wb = '0;

    always @(posedge clk) begin
        bit rdy;
        bit done;
        if (!rst_n) begin
            nibq.delete();
            m_valid = 0;
            m_ovf   = 0;
            m_wa    = '0;
            m_wb    = '0;
            armed   = 1;
        end else begin
            rdy  = (nibq.size() != N - 1) || !m_valid || out_ready;
            done = 0;
            if (in_valid && rdy) begin
                nibq.push_back(in_data);
                if (nibq.size() == N) begin
                    m_wa = '0;
                    m_wb = '0;
                    for (int i = 0; i < N; i++) begin
                        m_wa = m_wa | (16'(nibq[i]) << ((N - 1 - i) * DW));
                        m_wb = m_wb | (16'(nibq[i]) << (i * DW));
                    end
                    m_valid = 1;
                    done    = 1;
                    nibq.delete();
                end
            end
            if (in_valid && !rdy)
                m_ovf = 1;
            if (m_valid && out_ready && !done)
                m_valid = 0;
        end
    end

    always @(negedge clk) begin
        bit exp_rdy;
        if (armed) begin
            exp_rdy = (nibq.size() != N - 1) || !m_valid || out_ready;
            chk("a_nib_cnt", 32'(ia.nib_cnt), 32'(nibq.size()));
            chk("b_nib_cnt", 32'(ib.nib_cnt), 32'(nibq.size()));
            chk("a_out_valid", 32'(ia.out_valid), 32'(m_valid));
            chk("b_out_valid", 32'(ib.out_valid), 32'(m_valid));
            chk("a_overflow", 32'(ia.overflow), 32'(m_ovf));
            chk("b_overflow", 32'(ib.overflow), 32'(m_ovf));
            chk("a_in_ready", 32'(ia.in_ready), 32'(exp_rdy));
            chk("b_in_ready", 32'(ib.in_ready), 32'(exp_rdy));
            if (m_valid) begin
                chk("a_out_data", 32'(ia.out_data), 32'(m_wa));
                chk("b_out_data", 32'(ib.out_data), 32'(m_wb));
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] d,
                        input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t1[4];
        int exp_cnt[4];
        t1 = '{4'hA, 4'h5, 4'h3, 4'hC};
        exp_cnt = '{1, 2, 3, 0};

        rst_n = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_nib_cnt", 32'(ia.nib_cnt), 0);
        chk("rst_out_valid", 32'(ia.out_valid), 0);
        chk("rst_out_data", 32'(ia.out_data), 0);
        chk("rst_overflow", 32'(ia.overflow), 0);
        rst_n = 1'b1;
        step(0, 0, 1);

        for (int i = 0; i < 4; i++) begin
            step(1, t1[i], 1);
            chk("t1_nib_cnt", 32'(ia.nib_cnt), 32'(exp_cnt[i]));
        end
        chk("t1_valid", 32'(ia.out_valid), 1);
        chk("t1_word_msb", 32'(ia.out_data), 32'h0000_A53C);
        chk("t1_word_lsb", 32'(ib.out_data), 32'h0000_C35A);
        step(0, 0, 1);
        chk("t1_drain", 32'(ia.out_valid), 0);

        for (int i = 1; i <= 4; i++)
            step(1, 4'(i), 1);
        chk("t2_word_lsb", 32'(ib.out_data), 32'h0000_4321);
        chk("t2_word_msb", 32'(ia.out_data), 32'h0000_1234);
        step(0, 0, 1);

        for (int i = 1; i <= 7; i++)
            step(1, 4'(i), 0);
        chk("t3_held", 32'(ia.out_data), 32'h0000_1234);
        chk("t3_stall", 32'(ia.in_ready), 0);
        step(1, 4'h9, 0);
        chk("t4_ovf", 32'(ia.overflow), 1);
        chk("t4_cnt_hold", 32'(ia.nib_cnt), 3);
        step(1, 4'h8, 1);
        chk("t3_next_valid", 32'(ia.out_valid), 1);
        chk("t3_next_word", 32'(ia.out_data), 32'h0000_5678);
        step(0, 0, 1);
        chk("t4_ovf_sticky", 32'(ia.overflow), 1);

        step(1, 4'hF, 1);
        step(1, 4'hE, 1);
        rst_n = 1'b0;
        step(0, 0, 1);
        rst_n = 1'b1;
        chk("t5_cnt", 32'(ia.nib_cnt), 0);
        chk("t5_valid", 32'(ia.out_valid), 0);
        chk("t5_ovf_clr", 32'(ia.overflow), 0);
        for (int i = 1; i <= 4; i++)
            step(1, 4'(i), 1);
        chk("t5_word", 32'(ia.out_data), 32'h0000_1234);
        step(0, 0, 1);

        for (int i = 0; i < 12; i++) begin
            chk("t6_in_ready", 32'(ia.in_ready), 1);
            step(1, 4'(i), 1);
            if (i == 3)
                chk("t6_w0", 32'(ia.out_data), 32'h0000_0123);
            if (i == 7)
                chk("t6_w1", 32'(ia.out_data), 32'h0000_4567);
            if (i == 11)
                chk("t6_w2", 32'(ia.out_data), 32'h0000_89AB);
        end
        chk("t6_ovf", 32'(ia.overflow), 0);
        step(0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step(($urandom_range(0, 3) != 0), 4'($urandom),
                 ($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;
        step(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
